// File: rtl/motor_pkg.sv
// -----------------------------------------------------------------------------
// motor_pkg
// Shared definitions for the motor drive slice: drive command encodings,
// H-bridge direction encodings and the duty word width.
// -----------------------------------------------------------------------------
package motor_pkg;

  localparam int DUTY_W = 10;

  localparam logic [DUTY_W-1:0] DUTY_MAX = 10'd1023;

  // H-bridge {IN1,IN2}
  localparam logic [1:0] DIR_FWD = 2'b10;
  localparam logic [1:0] DIR_REV = 2'b01;

  // Drive commands from the line tracker; 6 and 7 are not listed and decode as stop
  typedef enum logic [2:0] {
    CMD_TURN_LEFT   = 3'd0,
    CMD_TURN_RIGHT  = 3'd1,
    CMD_GO_STRAIGHT = 3'd2,
    CMD_STOP        = 3'd3,
    CMD_SHARP_LEFT  = 3'd4,
    CMD_SHARP_RIGHT = 3'd5
  } cmd_e;

endpackage

// File: rtl/motor_ramp_channel.sv
// -----------------------------------------------------------------------------
// motor_ramp_channel
// One wheel's worth of drive logic: scales the raw target by the modulation
// word, slews the applied duty toward it once per ramp tick with the
// direction-reversal interlock, and produces the PWM output from a duty value
// latched at each PWM period boundary.
//
// Ports:
//   clk         in   system clock
//   reset       in   asynchronous active-low reset
//   tick        in   one-cycle ramp tick from the shared divider
//   pwm_count   in   shared free-running PWM counter (0..1023)
//   raw_target  in   unscaled target duty from the command decode
//   modulation  in   scale factor, 1023 = unity
//   want_dir    in   direction requested by the command decode
//   keep_dir    in   1 = no direction request, hold the current direction
//   pwm         out  registered PWM output
//   dir         out  current H-bridge direction
//   duty        out  current applied duty
// -----------------------------------------------------------------------------
module motor_ramp_channel
  import motor_pkg::*;
#(
  parameter int RAMP_STEP = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic [DUTY_W-1:0] pwm_count,
  input  logic [DUTY_W-1:0] raw_target,
  input  logic [DUTY_W-1:0] modulation,
  input  logic [1:0]        want_dir,
  input  logic              keep_dir,
  output logic              pwm,
  output logic [1:0]        dir,
  output logic [DUTY_W-1:0] duty
);

  localparam logic [DUTY_W:0] STEP = (DUTY_W+1)'(RAMP_STEP);

  logic [2*DUTY_W-1:0] product;
  logic [DUTY_W-1:0]   target;
  logic [1:0]          desired_dir;
  logic [DUTY_W:0]     duty_ext;
  logic [DUTY_W:0]     target_ext;
  logic [DUTY_W-1:0]   duty_next;
  logic [1:0]          dir_next;
  logic [DUTY_W-1:0]   latched_duty;

  // Unity modulation bypasses the multiply, because 1023/1024 would otherwise
  // shave one count off every full-scale target.
  always_comb begin
    product = (2*DUTY_W)'(raw_target) * (2*DUTY_W)'(modulation);
    if (modulation == DUTY_MAX) begin
      target = raw_target;
    end else begin
      target = DUTY_W'(product >> DUTY_W);
    end
  end

  // Slew and interlock. A pending reversal first drains the duty to zero, then
  // flips the bridge on a tick of its own, so the direction can never change
  // while the wheel is being driven. Arithmetic is one bit wider so the
  // clamps against 0 and the target are plain comparisons.
  always_comb begin
    desired_dir = keep_dir ? dir : want_dir;
    duty_ext    = {1'b0, duty};
    target_ext  = {1'b0, target};
    duty_next   = duty;
    dir_next    = dir;
    if (desired_dir != dir) begin
      if (duty == '0) begin
        dir_next = desired_dir;
      end else if (duty_ext > STEP) begin
        duty_next = DUTY_W'(duty_ext - STEP);
      end else begin
        duty_next = '0;
      end
    end else if (duty_ext < target_ext) begin
      if ((target_ext - duty_ext) > STEP) begin
        duty_next = DUTY_W'(duty_ext + STEP);
      end else begin
        duty_next = target;
      end
    end else if (duty_ext > target_ext) begin
      if ((duty_ext - target_ext) > STEP) begin
        duty_next = DUTY_W'(duty_ext - STEP);
      end else begin
        duty_next = target;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      duty <= '0;
      dir  <= DIR_FWD;
    end else if (tick) begin
      duty <= duty_next;
      dir  <= dir_next;
    end
  end

  // The compare uses a copy of the duty taken at the end of each period so a
  // ramp step landing mid-period cannot produce a runt or stretched pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      latched_duty <= '0;
      pwm          <= 1'b0;
    end else begin
      if (pwm_count == DUTY_MAX) begin
        latched_duty <= duty;
      end
      pwm <= (pwm_count < latched_duty);
    end
  end

endmodule

// File: rtl/motor_drive.sv
// -----------------------------------------------------------------------------
// motor_drive
// Turns the line-tracker drive command and per-wheel modulation words into
// two slew-limited PWM duties plus H-bridge direction pins. Holds the command
// decode, the shared ramp tick divider and the shared PWM counter; each wheel
// is a motor_ramp_channel.
//
// Ports:
//   clk               in   system clock
//   reset             in   asynchronous active-low reset
//   state             in   drive command (motor_pkg::cmd_e, 6/7 = stop)
//   modulation_left   in   left wheel scale, 1023 = unity
//   modulation_right  in   right wheel scale, 1023 = unity
//   pwm_left          out  left motor PWM
//   pwm_right         out  right motor PWM
//   dir_left          out  left H-bridge {IN1,IN2}
//   dir_right         out  right H-bridge {IN1,IN2}
//   duty_left         out  current applied left duty
//   duty_right        out  current applied right duty
// -----------------------------------------------------------------------------
module motor_drive
  import motor_pkg::*;
#(
  parameter int RAMP_DIV   = 10000,
  parameter int RAMP_STEP  = 8,
  parameter int FULL_DUTY  = 1023,
  parameter int TURN_DUTY  = 600,
  parameter int SHARP_DUTY = 400
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        state,
  input  logic [DUTY_W-1:0] modulation_left,
  input  logic [DUTY_W-1:0] modulation_right,
  output logic              pwm_left,
  output logic              pwm_right,
  output logic [1:0]        dir_left,
  output logic [1:0]        dir_right,
  output logic [DUTY_W-1:0] duty_left,
  output logic [DUTY_W-1:0] duty_right
);

  localparam int                TICK_W    = $clog2(RAMP_DIV);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(RAMP_DIV - 1);

  localparam logic [DUTY_W-1:0] FULL  = DUTY_W'(FULL_DUTY);
  localparam logic [DUTY_W-1:0] TURN  = DUTY_W'(TURN_DUTY);
  localparam logic [DUTY_W-1:0] SHARP = DUTY_W'(SHARP_DUTY);

  logic [TICK_W-1:0] tick_count;
  logic              tick;
  logic [DUTY_W-1:0] pwm_count;

  logic [DUTY_W-1:0] raw_left;
  logic [DUTY_W-1:0] raw_right;
  logic [1:0]        want_dir_left;
  logic [1:0]        want_dir_right;
  logic              keep_dir;

  // Stop carries no direction request so a coasting wheel keeps its bridge
  // orientation instead of scheduling a pointless reversal.
  always_comb begin
    raw_left       = '0;
    raw_right      = '0;
    want_dir_left  = DIR_FWD;
    want_dir_right = DIR_FWD;
    keep_dir       = 1'b0;
    case (state)
      CMD_GO_STRAIGHT: begin
        raw_left  = FULL;
        raw_right = FULL;
      end
      CMD_TURN_LEFT: begin
        raw_left  = TURN;
        raw_right = FULL;
      end
      CMD_TURN_RIGHT: begin
        raw_left  = FULL;
        raw_right = TURN;
      end
      CMD_SHARP_LEFT: begin
        raw_left      = SHARP;
        want_dir_left = DIR_REV;
        raw_right     = FULL;
      end
      CMD_SHARP_RIGHT: begin
        raw_left       = FULL;
        raw_right      = SHARP;
        want_dir_right = DIR_REV;
      end
      default: begin
        keep_dir = 1'b1;
      end
    endcase
  end

  assign tick = (tick_count == TICK_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_count <= '0;
    end else if (tick) begin
      tick_count <= '0;
    end else begin
      tick_count <= tick_count + 1'b1;
    end
  end

  // Period of 1024 falls out of the natural 10-bit wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pwm_count <= '0;
    end else begin
      pwm_count <= pwm_count + 1'b1;
    end
  end

  motor_ramp_channel #(
    .RAMP_STEP (RAMP_STEP)
  ) u_left (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .pwm_count  (pwm_count),
    .raw_target (raw_left),
    .modulation (modulation_left),
    .want_dir   (want_dir_left),
    .keep_dir   (keep_dir),
    .pwm        (pwm_left),
    .dir        (dir_left),
    .duty       (duty_left)
  );

  motor_ramp_channel #(
    .RAMP_STEP (RAMP_STEP)
  ) u_right (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .pwm_count  (pwm_count),
    .raw_target (raw_right),
    .modulation (modulation_right),
    .want_dir   (want_dir_right),
    .keep_dir   (keep_dir),
    .pwm        (pwm_right),
    .dir        (dir_right),
    .duty       (duty_right)
  );

endmodule

// File: doc/motor_drive.md
Name: motor_drive

Overview:
- Downstream consumer of the line-tracker command state and the curvature modulation words.
- Turns the 3-bit drive command plus the per-wheel 10-bit modulation into two slew-limited PWM duties and H-bridge direction pins.
- Interlocks direction reversal so it can only happen at zero duty.
- Sits between the tracker/modulation logic and the motor driver pins.

Parameters:
- RAMP_DIV, 10000: clk cycles per ramp tick (≥2).
- RAMP_STEP, 8: maximum duty change per ramp tick (1..1023).
- FULL_DUTY, 1023: outer/straight wheel target duty.
- TURN_DUTY, 600: inner wheel target duty on a slow turn.
- SHARP_DUTY, 400: inner wheel reverse target duty on a sharp turn.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- state  in  3  drive command: 0 turn_left, 1 turn_right, 2 go_straight, 3 stop, 4 sharp_turn_left, 5 sharp_turn_right; 6/7 are treated as stop
- modulation_left  in  10  left wheel scale factor; 1023 = unity
- modulation_right  in  10  right wheel scale factor; 1023 = unity
- pwm_left  out  1  left motor PWM
- pwm_right  out  1  right motor PWM
- dir_left  out  2  left H-bridge {IN1,IN2}: 2'b10 forward, 2'b01 reverse
- dir_right  out  2  right H-bridge, same encoding
- duty_left  out  10  current applied left duty (also used for debug)
- duty_right  out  10  current applied right duty

Behaviour:
- Reset (reset==0, asynchronous): duty_left/right=0, dir_left/right=2'b10, pwm_left/right=0, tick counter=0, PWM counter=0, latched duties=0.
- Command decode, combinational, as (left dir/raw target, right dir/raw target):
  - go_straight: fwd FULL / fwd FULL
  - turn_left: fwd TURN / fwd FULL
  - turn_right: fwd FULL / fwd TURN
  - sharp_turn_left: rev SHARP / fwd FULL
  - sharp_turn_right: fwd FULL / rev SHARP
  - stop or 6/7: target 0 on both wheels, desired dir = current dir
- Scaling per wheel:
  - If modulation==1023, target = raw.
  - Otherwise target = (raw*modulation)[19:10], using a 20-bit product truncated, not rounded.
- Ramp tick: a counter runs 0..RAMP_DIV-1. The tick is the cycle it equals RAMP_DIV-1, after which it wraps to 0.
- Per wheel on each tick, using the inputs sampled that cycle:
  - desired dir ≠ current dir and duty>0: duty ← max(duty-RAMP_STEP, 0); dir unchanged.
  - desired dir ≠ current dir and duty==0: dir ← desired; duty stays 0 on this tick.
  - Dirs match: duty moves toward target by at most RAMP_STEP and lands exactly on target, with no overshoot and no wrap below 0 or above 1023.
- Between ticks, duty and dir hold.
- Inputs may change any cycle; only tick-cycle values matter.
- Invariant: dir never changes while the corresponding duty is ≠ 0.
- PWM:
  - A 10-bit counter free-runs 0..1023 (period 1024).
  - At counter==1023 the latched duty is loaded from duty_x.
  - pwm_x = (counter < latched duty), registered.
  - Duty 0 gives a constant low output; duty 1023 gives 1023 high cycles per 1024.
- Latency: a command change affects duty_x at the next tick. It reaches the pwm pin at the next PWM period boundary, plus 1 cycle for the output register.
- Reset mid-ramp: all state clears immediately. Ramp restarts from 0 after release.

Decomposition:
- Shared package (motor_pkg):
  - Command encodings 0..5.
  - DIR_FWD=2'b10, DIR_REV=2'b01.
  - Duty width constant 10.
- One sub-module, motor_ramp_channel, instantiated once per wheel. It holds the scaling, slew/interlock, latched duty and PWM compare.
- The top level holds the decode, the shared tick counter and the shared PWM counter.

Test Plan:
- Use RAMP_DIV=4, RAMP_STEP=100 unless noted.
- Reset at start: all outputs 0, dir=2'b10, both pwm low for 2048 cycles.
- go_straight, modulation=1023/1023: duty_left steps 0,100,…,1000,1023 on successive ticks, one tick per 4 cycles, 11 ticks total, then holds. dir stays 2'b10.
- go_straight, modulation_left=823: left duty settles at 822 (1023*823>>10); right settles at 1023.
- From a steady go_straight at 1023, switch to sharp_turn_left:
  - duty_left 923,823,…,23,0.
  - Next tick: dir_left=2'b01 with duty 0.
  - Then ramps 100..400. dir_left never changes while duty≠0.
  - Right wheel unaffected.
- PWM with duty held at 256: pwm_left high exactly 256 of every 1024 cycles. A duty change written mid-period only takes effect after counter==1023.
- Apply state=6 after a ramp to 1023: both ramp to 0 and dirs hold. Assert reset asynchronously mid-ramp, between clk edges: outputs zero before the next edge.
